// File: rtl/stream_queue_scoreboard.sv
// In-order valid/ready scoreboard: queues expected words on input handshakes
// and checks data, latency, overflow, underflow and timeout on the output side.
module stream_queue_scoreboard #(
   parameter int P_IN_DWIDTH  = 32,
   parameter int P_OUT_DWIDTH = 8,
   parameter int P_DEPTH      = 4,
   parameter int P_SEL_MSB    = 0,
   parameter int P_MIN_LAT    = 1,
   parameter int P_MAX_LAT    = 16,
   parameter int P_CNT_WIDTH  = 32,
   parameter int P_REPORT     = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   input  logic                           in_ready,
   input  logic [P_IN_DWIDTH-1:0]         in_data,
   input  logic                           out_valid,
   input  logic                           out_ready,
   input  logic [P_OUT_DWIDTH-1:0]        out_data,
   output logic [$clog2(P_DEPTH+1)-1:0]   pending,
   output logic [P_CNT_WIDTH-1:0]         in_count,
   output logic [P_CNT_WIDTH-1:0]         out_count,
   output logic [P_CNT_WIDTH-1:0]         err_count,
   output logic                           err_flag,
   output logic [2:0]                     err_code
);

   localparam int PW = $clog2(P_DEPTH + 1);
   localparam int AW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
   localparam int CW = P_CNT_WIDTH;

   typedef logic [CW-1:0] cnt_t;

   if (P_OUT_DWIDTH > P_IN_DWIDTH) begin : g_bad_width
      $error("stream_queue_scoreboard: P_OUT_DWIDTH > P_IN_DWIDTH");
   end

   logic [P_OUT_DWIDTH-1:0] in_sel;
   logic                    unused_in;
   assign unused_in = ^in_data;

   if (P_SEL_MSB != 0) begin : g_msb
      assign in_sel = in_data[P_IN_DWIDTH-1 -: P_OUT_DWIDTH];
   end else begin : g_lsb
      assign in_sel = in_data[P_OUT_DWIDTH-1:0];
   end

   logic [P_OUT_DWIDTH-1:0] exp_q [P_DEPTH];
   logic [P_OUT_DWIDTH-1:0] exp_d [P_DEPTH];
   cnt_t                    stamp_q [P_DEPTH];
   cnt_t                    stamp_d [P_DEPTH];
   logic [P_DEPTH-1:0]      to_q, to_d;
   logic [AW-1:0]           head_q, head_d, tail_q, tail_d;
   logic [PW-1:0]           cnt_q, cnt_d;
   cnt_t                    cyc_q, cyc_d;
   cnt_t                    in_cnt_q, in_cnt_d;
   cnt_t                    out_cnt_q, out_cnt_d;
   cnt_t                    err_cnt_q, err_cnt_d;
   logic                    err_flag_q, err_flag_d;
   logic [2:0]              err_code_q, err_code_d;

   logic in_fire, out_fire, empty, full, pop, push;
   logic e_und, e_mis, e_early, e_ovf, e_to;
   logic [1:0] n_err;
   logic [P_OUT_DWIDTH-1:0] h_exp;
   cnt_t h_stamp, lat;
   logic h_to;

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(P_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic cnt_t sat(input cnt_t v, input logic [1:0] n);
      logic [CW:0] s;
      s = {1'b0, v} + {{(CW-1){1'b0}}, n};
      return s[CW] ? '1 : s[CW-1:0];
   endfunction

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;
   assign empty    = (cnt_q == '0);
   assign full     = (cnt_q == PW'(P_DEPTH));
   assign h_exp    = exp_q[head_q];
   assign h_stamp  = stamp_q[head_q];
   assign h_to     = to_q[head_q];
   assign lat      = cyc_q - h_stamp;

   // A word pushed this cycle is not yet at the head, so it cannot
   // satisfy a same-cycle output on an empty queue.
   assign pop     = out_fire && !empty;
   assign e_und   = out_fire && empty;
   assign e_mis   = pop && (out_data !== h_exp);
   assign e_early = pop && !e_mis && !h_to && (lat < CW'(P_MIN_LAT));
   assign push    = in_fire && (!full || pop);
   assign e_ovf   = in_fire && full && !pop;
   assign e_to    = (P_MAX_LAT > 0) && !empty && !pop && !h_to &&
                    (lat >= CW'(P_MAX_LAT + 1));
   assign n_err   = {1'b0, e_und | e_mis | e_early} +
                    {1'b0, e_ovf} + {1'b0, e_to};

   always_comb begin
      exp_d      = exp_q;
      stamp_d    = stamp_q;
      to_d       = to_q;
      head_d     = head_q;
      tail_d     = tail_q;
      cyc_d      = cyc_q + 1'b1;
      if (e_to)
         to_d[head_q] = 1'b1;
      if (pop)
         head_d = nxt(head_q);
      if (push) begin
         exp_d[tail_q]   = in_sel;
         stamp_d[tail_q] = cyc_q;
         to_d[tail_q]    = 1'b0;
         tail_d          = nxt(tail_q);
      end
      cnt_d      = cnt_q + PW'(push) - PW'(pop);
      in_cnt_d   = in_fire ? sat(in_cnt_q, 2'd1) : in_cnt_q;
      out_cnt_d  = out_fire ? sat(out_cnt_q, 2'd1) : out_cnt_q;
      err_cnt_d  = sat(err_cnt_q, n_err);
      err_flag_d = err_flag_q || (n_err != 2'd0);
      err_code_d = err_code_q;
      if (e_und)        err_code_d = 3'd2;
      else if (e_mis)   err_code_d = 3'd1;
      else if (e_early) err_code_d = 3'd4;
      else if (e_ovf)   err_code_d = 3'd3;
      else if (e_to)    err_code_d = 3'd5;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         to_q       <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         cnt_q      <= '0;
         cyc_q      <= '0;
         in_cnt_q   <= '0;
         out_cnt_q  <= '0;
         err_cnt_q  <= '0;
         err_flag_q <= 1'b0;
         err_code_q <= 3'd0;
      end else begin
         exp_q      <= exp_d;
         stamp_q    <= stamp_d;
         to_q       <= to_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         cnt_q      <= cnt_d;
         cyc_q      <= cyc_d;
         in_cnt_q   <= in_cnt_d;
         out_cnt_q  <= out_cnt_d;
         err_cnt_q  <= err_cnt_d;
         err_flag_q <= err_flag_d;
         err_code_q <= err_code_d;
      end
   end

   assign pending   = cnt_q;
   assign in_count  = in_cnt_q;
   assign out_count = out_cnt_q;
   assign err_count = err_cnt_q;
   assign err_flag  = err_flag_q;
   assign err_code  = err_code_q;

   always @(posedge clk) begin
      if ((P_REPORT != 0) && rst_n) begin
         if (e_und)
            $error("%0t sb code 2 underflow act=%0h", $time, out_data);
         if (e_mis)
            $error("%0t sb code 1 mismatch exp=%0h act=%0h",
                   $time, h_exp, out_data);
         if (e_early)
            $error("%0t sb code 4 early lat=%0d exp=%0h act=%0h",
                   $time, lat, h_exp, out_data);
         if (e_ovf)
            $error("%0t sb code 3 overflow dropped=%0h", $time, in_sel);
         if (e_to)
            $error("%0t sb code 5 timeout exp=%0h", $time, h_exp);
         if (out_valid && !out_ready && empty)
            $warning("%0t sb out_valid with empty queue", $time);
      end
   end

   final begin
      if (P_REPORT != 0) begin
         if (in_cnt_q != out_cnt_q)
            $error("sb in_count %0d != out_count %0d", in_cnt_q, out_cnt_q);
         if (cnt_q != '0)
            $error("sb %0d entries still pending", cnt_q);
         if (err_cnt_q == '0 && in_cnt_q == out_cnt_q && cnt_q == '0)
            $info("sb PASS in=%0d out=%0d", in_cnt_q, out_cnt_q);
         else
            $error("sb FAIL err=%0d in=%0d out=%0d pending=%0d",
                   err_cnt_q, in_cnt_q, out_cnt_q, cnt_q);
      end
   end

endmodule

// File: tb/tb_stream_queue_scoreboard.sv
// Directed bench for stream_queue_scoreboard: one default instance and one
// with MSB select, min latency 3 and max latency 5, sharing one stimulus.
module tb_stream_queue_scoreboard;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;

   logic [2:0]  pend_a, pend_b;
   logic [31:0] inc_a, inc_b, outc_a, outc_b, errc_a, errc_b;
   logic        flag_a, flag_b;
   logic [2:0]  code_a, code_b;

   int n_vec  = 0;
   int n_miss = 0;

   stream_queue_scoreboard #(
      .P_REPORT (0)
   ) u_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .pending   (pend_a),
      .in_count  (inc_a),
      .out_count (outc_a),
      .err_count (errc_a),
      .err_flag  (flag_a),
      .err_code  (code_a)
   );

   stream_queue_scoreboard #(
      .P_SEL_MSB (1),
      .P_MIN_LAT (3),
      .P_MAX_LAT (5),
      .P_REPORT  (0)
   ) u_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .pending   (pend_b),
      .in_count  (inc_b),
      .out_count (outc_b),
      .err_count (errc_b),
      .err_flag  (flag_b),
      .err_code  (code_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, want %0h", tag, act, exp);
      end
   endtask

   task automatic step(input logic vi, input logic [31:0] di,
                       input logic vo, input logic ro,
                       input logic [7:0] dout);
      in_valid  = vi;
      in_ready  = 1'b1;
      in_data   = di;
      out_valid = vo;
      out_ready = ro;
      out_data  = dout;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, 32'h0, 1'b0, 1'b1, 8'h00);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_ready  = 1'b0;
      in_data   = '0;
      out_valid = 1'b0;
      out_ready = 1'b0;
      out_data  = '0;

      // basic in-order traffic at latency 2
      do_reset();
      chk("rst_pend",  32'(pend_a), 32'd0);
      chk("rst_inc",   inc_a,       32'd0);
      chk("rst_outc",  outc_a,      32'd0);
      chk("rst_errc",  errc_a,      32'd0);
      chk("rst_flag",  32'(flag_a), 32'd0);
      chk("rst_code",  32'(code_a), 32'd0);
      step(1'b1, 32'h11223344, 1'b0, 1'b1, 8'h00);
      chk("b2b_p1", 32'(pend_a), 32'd1);
      step(1'b1, 32'h55667788, 1'b0, 1'b1, 8'h00);
      chk("b2b_p2", 32'(pend_a), 32'd2);
      step(1'b1, 32'h99AABBCC, 1'b1, 1'b1, 8'h44);
      chk("b2b_p3", 32'(pend_a), 32'd2);
      step(1'b0, 32'h0, 1'b1, 1'b1, 8'h88);
      chk("b2b_p4", 32'(pend_a), 32'd1);
      step(1'b0, 32'h0, 1'b1, 1'b1, 8'hCC);
      chk("b2b_p5", 32'(pend_a), 32'd0);
      chk("b2b_err", errc_a, 32'd0);
      chk("b2b_in",  inc_a,  32'd3);
      chk("b2b_out", outc_a, 32'd3);
      chk("b2b_flg", 32'(flag_a), 32'd0);

      // byte select: b takes MSB, a takes LSB
      do_reset();
      step(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 8'h00);
      idle(2);
      step(1'b0, 32'h0, 1'b1, 1'b1, 8'hDE);
      chk("msb_ok_err", errc_b, 32'd0);
      chk("msb_ok_pnd", 32'(pend_b), 32'd0);
      chk("lsb_mis_cd", 32'(code_a), 32'd1);
      chk("lsb_mis_ct", errc_a, 32'd1);
      step(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 8'h00);
      idle(2);
      step(1'b0, 32'h0, 1'b1, 1'b1, 8'hEF);
      chk("msb_mis_cd", 32'(code_b), 32'd1);
      chk("msb_mis_ct", errc_b, 32'd1);
      chk("msb_mis_fl", 32'(flag_b), 32'd1);
      chk("lsb_ok_ct",  errc_a, 32'd1);

      // overflow on a full queue, then pop+push while full
      do_reset();
      for (int i = 1; i <= 4; i++)
         step(1'b1, 32'(i), 1'b0, 1'b1, 8'h00);
      chk("full_pnd", 32'(pend_a), 32'd4);
      chk("full_err", errc_a, 32'd0);
      step(1'b1, 32'h5, 1'b0, 1'b1, 8'h00);
      chk("ovf_code", 32'(code_a), 32'd3);
      chk("ovf_cnt",  errc_a, 32'd1);
      chk("ovf_pnd",  32'(pend_a), 32'd4);
      step(1'b1, 32'h6, 1'b1, 1'b1, 8'h01);
      chk("pp_cnt",  errc_a, 32'd1);
      chk("pp_pnd",  32'(pend_a), 32'd4);
      chk("pp_code", 32'(code_a), 32'd3);

      // underflow, including same-cycle push on empty
      do_reset();
      step(1'b1, 32'h77, 1'b1, 1'b1, 8'h77);
      chk("und_code", 32'(code_a), 32'd2);
      chk("und_cnt",  errc_a, 32'd1);
      chk("und_pnd",  32'(pend_a), 32'd1);
      step(1'b0, 32'h0, 1'b1, 1'b1, 8'h77);
      chk("und_pop",  32'(pend_a), 32'd0);
      chk("und_cnt2", errc_a, 32'd1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 8'h00);
      chk("warn_cnt", errc_a, 32'd1);
      chk("warn_out", outc_a, 32'd2);

      // early output and timeout on b
      do_reset();
      step(1'b1, 32'hA1000000, 1'b0, 1'b1, 8'h00);
      idle(1);
      step(1'b0, 32'h0, 1'b1, 1'b1, 8'hA1);
      chk("early_cd", 32'(code_b), 32'd4);
      chk("early_ct", errc_b, 32'd1);
      step(1'b1, 32'hB2000000, 1'b0, 1'b1, 8'h00);
      idle(5);
      chk("to_age5", errc_b, 32'd1);
      idle(1);
      chk("to_age6", errc_b, 32'd2);
      chk("to_code", 32'(code_b), 32'd5);
      idle(4);
      chk("to_once", errc_b, 32'd2);
      chk("to_pnd",  32'(pend_b), 32'd1);
      step(1'b0, 32'h0, 1'b1, 1'b1, 8'hB2);
      chk("to_pop_ct", errc_b, 32'd2);
      chk("to_pop_pn", 32'(pend_b), 32'd0);

      // reset with entries pending, then clean traffic
      do_reset();
      step(1'b0, 32'h0, 1'b1, 1'b1, 8'h00);
      for (int i = 0; i < 3; i++)
         step(1'b1, 32'(i), 1'b0, 1'b1, 8'h00);
      chk("mid_pnd",  32'(pend_a), 32'd3);
      chk("mid_flag", 32'(flag_a), 32'd1);
      do_reset();
      chk("mr_pnd",  32'(pend_a), 32'd0);
      chk("mr_in",   inc_a,       32'd0);
      chk("mr_out",  outc_a,      32'd0);
      chk("mr_err",  errc_a,      32'd0);
      chk("mr_flag", 32'(flag_a), 32'd0);
      chk("mr_code", 32'(code_a), 32'd0);
      step(1'b1, 32'h5A, 1'b0, 1'b1, 8'h00);
      step(1'b0, 32'h0, 1'b1, 1'b1, 8'h5A);
      chk("cl_err", errc_a, 32'd0);
      chk("cl_in",  inc_a,  32'd1);
      chk("cl_out", outc_a, 32'd1);
      chk("cl_pnd", 32'(pend_a), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
